// File: rtl/dbus_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder_pkg
// Shared types and helpers for the data-bus SRAM responder:
//   - msize_t      : access size code carried with each request
//   - dbus_req_t   : request from the MEM stage (valid/addr/size/strobe/data)
//   - dbus_resp_t  : response to the MEM stage (addr_ok/data_ok/data)
//   - dsram_state_t: responder FSM states (IDLE, BUSY, RESP)
//   - LFSR_SEED    : reset value of the optional random-delay LFSR
//   - strobe_merge : byte-lane merge of a write into an existing word
// -----------------------------------------------------------------------------
package dbus_sram_responder_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dsram_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Replace each byte lane of old_word whose strobe bit is set with the
   // corresponding lane of new_word.
   function automatic logic [63:0] strobe_merge(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strobe);
      logic [63:0] merged;
      merged = old_word;
      for (int i = 0; i < 8; i++) begin
         if (strobe[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded with LFSR_SEED on reset.
// Only exists when DBUS_SRAM_RANDOM_DELAY_EN is defined; it supplies the
// extra wait cycles that stress the requester's stall path.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-low reset
//   en    in  advance the register this cycle
//   out   out current LFSR value
// -----------------------------------------------------------------------------
`ifdef DBUS_SRAM_RANDOM_DELAY_EN
module lfsr8
   import dbus_sram_responder_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] out
);

   logic [7:0] lfsr_reg;
   logic       feedback;

   // Taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
   assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_reg <= LFSR_SEED;
      end else if (en) begin
         lfsr_reg <= {lfsr_reg[6:0], feedback};
      end
   end

   assign out = lfsr_reg;

endmodule
`endif

// File: rtl/dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder
// Memory-side responder for the core data bus, backed by an internal array of
// 64-bit words. One request is served at a time: IDLE latches the request,
// BUSY waits LATENCY cycles and performs the access on its last cycle, RESP
// pulses addr_ok/data_ok for one cycle with the response data.
// Parameters:
//   MEM_WORDS  number of 64-bit words (power of two); addresses wrap modulo it
//   BASE_ADDR  byte address mapped to word 0
//   LATENCY    cycles spent in BUSY (1..15)
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset (array contents are kept)
//   dreq   in  dbus_req_t request
//   dresp  out dbus_resp_t registered response
// Build option:
//   DBUS_SRAM_RANDOM_DELAY_EN adds 0..3 pseudo-random wait cycles per request.
// -----------------------------------------------------------------------------
module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          LATENCY   = 2
)
(
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);

   localparam int AW = $clog2(MEM_WORDS);
   // Wide enough for LATENCY-1 plus up to 3 random extra cycles.
   localparam int CW = 5;

   dsram_state_t  state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   dbus_req_t     req_reg, req_next;
   logic          ok_reg, ok_next;
   logic [63:0]   rdata_reg, rdata_next;

   logic [63:0]   mem [MEM_WORDS];

   logic [63:0]   offset;
   logic [AW-1:0] word_idx;
   logic [63:0]   cur_word;
   logic          do_write;
   logic [CW-1:0] load_value;
   logic          unused_bits;

   // Word index from the latched address; the subtraction wraps naturally,
   // and the upper offset bits are dropped so the array aliases.
   assign offset   = req_reg.addr - BASE_ADDR;
   assign word_idx = offset[AW+2:3];
   assign cur_word = mem[word_idx];

`ifdef DBUS_SRAM_RANDOM_DELAY_EN
   logic [7:0] lfsr_q;
   logic       unused_lfsr;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .out   (lfsr_q)
   );

   assign load_value  = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
   assign unused_lfsr = ^lfsr_q[7:2];
`else
   assign load_value = CW'(LATENCY - 1);
`endif

   // size is carried along but not interpreted; low address bits select a
   // byte within the word and are left to the requester.
   assign unused_bits = ^{req_reg.valid, req_reg.size, offset[63:AW+3], offset[2:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         count_reg <= '0;
         req_reg   <= '0;
         ok_reg    <= 1'b0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         req_reg   <= req_next;
         ok_reg    <= ok_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      req_next   = req_reg;
      ok_next    = 1'b0;
      rdata_next = rdata_reg;
      do_write   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (dreq.valid) begin
               req_next   = dreq;
               count_next = load_value;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (count_reg != '0) begin
               count_next = count_reg - CW'(1);
            end else begin
               // Access happens on the last BUSY cycle so RESP carries it.
               state_next = RESP;
               ok_next    = 1'b1;
               if (req_reg.strobe == 8'h00) begin
                  rdata_next = cur_word;
               end else begin
                  rdata_next = '0;
                  do_write   = 1'b1;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // No reset on the array: contents survive reset. A write is only issued
   // from BUSY, so a reset asserted before the final BUSY edge drops it.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[word_idx] <= strobe_merge(cur_word, req_reg.data, req_reg.strobe);
      end
   end

   assign dresp.addr_ok = ok_reg;
   assign dresp.data_ok = ok_reg;
   assign dresp.data    = rdata_reg;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_dbus_sram_responder
// Directed and randomized bench for dbus_sram_responder (default parameters).
// The reference memory is a byte-addressed associative array; expected data,
// latency and pulse counts come from it and from the timing rules.
// -----------------------------------------------------------------------------
module tb_dbus_sram_responder;
   import dbus_sram_responder_pkg::*;

   localparam int          MEM_WORDS = 4096;
   localparam logic [63:0] BASE_ADDR = 64'h8000_0000;
   localparam int          LATENCY   = 2;

   logic       clk;
   logic       reset;
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   int vectors;
   int miscompares;

   // Reference memory: byte offset within the array -> byte value.
   logic [7:0] ref_bytes [longint unsigned];

   dbus_sram_responder #(
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE_ADDR),
      .LATENCY   (LATENCY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (dreq),
      .dresp (dresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned word_base(input logic [63:0] addr);
      longint unsigned w;
      w = (longint'(addr - BASE_ADDR) / 8) % MEM_WORDS;
      return w * 8;
   endfunction

   function automatic bit ref_known(input logic [63:0] addr);
      longint unsigned b;
      b = word_base(addr);
      for (int i = 0; i < 8; i++) begin
         if (!ref_bytes.exists(b + longint'(i))) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [63:0] ref_read(input logic [63:0] addr);
      longint unsigned b;
      logic [63:0] w;
      b = word_base(addr);
      w = '0;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_bytes[b + longint'(i)];
      return w;
   endfunction

   task automatic ref_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strobe);
      longint unsigned b;
      b = word_base(addr);
      for (int i = 0; i < 8; i++) begin
         if (strobe[i]) ref_bytes[b + longint'(i)] = data[8*i +: 8];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request at the current cycle (cycle 0) and watch the response.
   // lat is the cycle number in which data_ok was first seen (-1 if never).
   task automatic run_req(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strobe, input int drop_at,
                          output logic [63:0] rdata, output logic aok,
                          output int lat, output int pulses);
      dreq.valid  = 1'b1;
      dreq.addr   = addr;
      dreq.size   = MSIZE8;
      dreq.strobe = strobe;
      dreq.data   = data;
      rdata  = '0;
      aok    = 1'b0;
      lat    = -1;
      pulses = 0;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (n == drop_at) dreq.valid = 1'b0;
         if (dresp.data_ok) begin
            pulses++;
            if (lat < 0) begin
               lat   = n;
               rdata = dresp.data;
               aok   = dresp.addr_ok;
            end
            dreq.valid = 1'b0;
         end
         if (lat >= 0 && n >= lat + 3) break;
      end
      dreq.valid = 1'b0;
   endtask

   // One full transaction checked against the reference model.
   task automatic xfer(input string tag, input logic [63:0] addr, input logic [63:0] data,
                       input logic [7:0] strobe, input int drop_at, output logic [63:0] rdata);
      logic aok;
      int   lat;
      int   pulses;
      bit   known;
      logic [63:0] exp;
      known = ref_known(addr);
      exp   = (strobe == 8'h00) ? ref_read(addr) : 64'h0;
      run_req(addr, data, strobe, drop_at, rdata, aok, lat, pulses);
      $display("xfer %s addr=%h strb=%h wdata=%h lat=%0d pulses=%0d rdata=%h",
               tag, addr, strobe, data, lat, pulses, rdata);
      check({tag, "_pulses"}, 64'(pulses), 64'd1);
`ifdef DBUS_SRAM_RANDOM_DELAY_EN
      check({tag, "_lat_range"}, 64'((lat >= LATENCY + 1) && (lat <= LATENCY + 4)), 64'd1);
`else
      check({tag, "_lat"}, 64'(lat), 64'(LATENCY + 1));
`endif
      check({tag, "_addr_ok"}, 64'(aok), 64'd1);
      if (strobe != 8'h00) begin
         check({tag, "_wresp"}, rdata, 64'h0);
         ref_write(addr, data, strobe);
      end else if (known) begin
         check({tag, "_rdata"}, rdata, exp);
      end
   endtask

   initial begin
      logic [63:0] rd;
      logic [63:0] pre;
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  s;

      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      dreq        = '0;

      // Reset state
      repeat (3) tick();
      check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
      check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
      check("rst_data", dresp.data, 64'h0);
      reset = 1'b1;
      tick();

      // Full write then read back
      xfer("wr_full", 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, rd);
      xfer("rd_full", 64'h8000_0010, 64'h0, 8'h00, 0, rd);
      check("rd_full_const", rd, 64'h1122334455667788);

      // Partial strobe
      xfer("wr_part", 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, rd);
      xfer("rd_part", 64'h8000_0010, 64'h0, 8'h00, 0, rd);
      check("rd_part_const", rd, 64'h11223344AAAAAAAA);

      // Wrap-around: 0x8000_8000 aliases word 0
      xfer("wr_wrap", 64'h8000_8000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 0, rd);
      xfer("rd_wrap", 64'h8000_0000, 64'h0, 8'h00, 0, rd);
      check("rd_wrap_const", rd, 64'hCAFE_F00D_DEAD_BEEF);

      // Request withdrawn in the second BUSY cycle
      xfer("rd_drop", 64'h8000_0010, 64'h0, 8'h00, 2, rd);
      repeat (3) begin
         check("drop_no_extra", 64'(dresp.data_ok), 64'd0);
         tick();
      end

      // Reset in the middle of a write
      pre = 64'h0123_4567_89AB_CDEF;
      xfer("wr_pre", 64'h8000_0020, pre, 8'hFF, 0, rd);
      xfer("rd_pre", 64'h8000_0020, 64'h0, 8'h00, 0, rd);
      dreq.valid  = 1'b1;
      dreq.addr   = 64'h8000_0020;
      dreq.strobe = 8'hFF;
      dreq.data   = 64'hFFFF_0000_FFFF_0000;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_ok", {62'h0, dresp.addr_ok, dresp.data_ok}, 64'h0);
      check("midrst_data", dresp.data, 64'h0);
      dreq.valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      xfer("rd_after_rst", 64'h8000_0020, 64'h0, 8'h00, 0, rd);
      check("rd_after_rst_const", rd, pre);

      // Randomized traffic over a small pool of words, with aliases and
      // ignored low address bits. Initialise the pool first.
      for (int i = 0; i < 16; i++) begin
         xfer("init", BASE_ADDR + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 0, rd);
      end
      for (int t = 0; t < 100; t++) begin
         a = BASE_ADDR + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) a = a + 64'h8000;
         d = {$urandom, $urandom};
         s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         xfer("rand", a, d, s, 0, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
